// File: rtl/ntt_addr_gen_pkg.sv
// Shared Kyber constants, mode/state encodings and the butterfly address/twiddle
// arithmetic used by the NTT address generator.
package ntt_addr_gen_pkg;

  localparam int KYBER_N        = 256;
  localparam int KYBER_Q        = 3329;
  localparam int NTT_LAYERS     = 7;
  localparam int BFLY_PER_LAYER = KYBER_N / 2;

  typedef enum logic [1:0] {
    MODE_NTT    = 2'd0,
    MODE_INVNTT = 2'd1
  } bu_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [7:0] addr_1;
    logic [7:0] addr_2;
    logic [6:0] zeta;
  } issue_t;

  typedef struct packed {
    logic       vld;
    logic [7:0] addr_1;
    logic [7:0] addr_2;
  } wb_word_t;

  localparam int WB_WORD_W = $bits(wb_word_t);

  // len is always a power of two, so group/offset reduce to shifts and masks:
  // 2*len*group + off == ((bf - off) << 1) | off.
  function automatic issue_t calc_issue(input logic [2:0] layer,
                                        input logic [6:0] bf,
                                        input logic       inv);
    logic [2:0] sh;
    logic [7:0] len;
    logic [7:0] bf_w;
    logic [7:0] grp;
    logic [7:0] off;
    issue_t     r;
    sh       = inv ? (layer + 3'd1) : (3'd7 - layer);
    len      = 8'd1 << sh;
    bf_w     = {1'b0, bf};
    grp      = bf_w >> sh;
    off      = bf_w & (len - 8'd1);
    r.addr_1 = ((bf_w - off) << 1) | off;
    r.addr_2 = r.addr_1 + len;
    r.zeta   = inv ? 7'((8'd128 >> layer) - 8'd1 - grp)
                   : 7'((8'd1 << layer) + grp);
    return r;
  endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// Control, coefficient-read and write-back bus between the transform sequencer
// and its requester / RAM / butterfly datapath.
interface ntt_addr_gen_if;
  logic       start;
  logic [1:0] mode;
  logic       busy;
  logic       done;
  logic       rd_en;
  logic [7:0] rd_addr_1;
  logic [7:0] rd_addr_2;
  logic [6:0] zeta_idx;
  logic [1:0] bu_mode;
  logic       wr_en;
  logic [7:0] wr_addr_1;
  logic [7:0] wr_addr_2;

  modport master (
    output start, mode,
    input  busy, done, rd_en, rd_addr_1, rd_addr_2, zeta_idx, bu_mode,
    input  wr_en, wr_addr_1, wr_addr_2
  );

  modport slave (
    input  start, mode,
    output busy, done, rd_en, rd_addr_1, rd_addr_2, zeta_idx, bu_mode,
    output wr_en, wr_addr_1, wr_addr_2
  );
endinterface

// File: rtl/wb_delay_line.sv
// Fixed-depth shift register carrying the read strobe and pair addresses forward
// to the write-back port, matching RAM read plus butterfly latency.
module wb_delay_line #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Cleared on reset so an aborted transform leaves no write-back in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Sequencer for a 256-point forward/inverse NTT: issues 128 butterfly reads per
// layer, drains the pipeline between layers and mirrors reads as write-backs.
module ntt_addr_gen
  import ntt_addr_gen_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int BU_LATENCY = 3
) (
  input logic            clk,
  input logic            rst_n,
  ntt_addr_gen_if.slave  bus
);

  localparam int D     = RD_LATENCY + BU_LATENCY;
  localparam int CNT_W = (D > 1) ? $clog2(D) : 1;

  state_t           state, state_nx;
  logic [2:0]       layer, layer_nx;
  logic [6:0]       bf, bf_nx;
  logic [CNT_W-1:0] dcnt, dcnt_nx;
  logic [1:0]       mode_q, mode_nx;
  logic             mode_ok;

  issue_t           issue_nx;
  logic             issue_vld_nx;

  logic             vld_p0;
  logic [7:0]       rd_addr_1_p0;
  logic [7:0]       rd_addr_2_p0;
  logic [6:0]       zeta_p0;

  wb_word_t         wb_in;
  wb_word_t         wb_out;

  assign mode_ok = (bus.mode == MODE_NTT) || (bus.mode == MODE_INVNTT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      layer  <= '0;
      bf     <= '0;
      dcnt   <= '0;
      mode_q <= '0;
    end else begin
      state  <= state_nx;
      layer  <= layer_nx;
      bf     <= bf_nx;
      dcnt   <= dcnt_nx;
      mode_q <= mode_nx;
    end
  end

  always_comb begin
    state_nx = state;
    layer_nx = layer;
    bf_nx    = bf;
    dcnt_nx  = dcnt;
    mode_nx  = mode_q;
    case (state)
      ST_IDLE: begin
        if (bus.start && mode_ok) begin
          state_nx = ST_ISSUE;
          layer_nx = '0;
          bf_nx    = '0;
          mode_nx  = bus.mode;
        end
      end
      ST_ISSUE: begin
        if (bf == 7'(BFLY_PER_LAYER - 1)) begin
          state_nx = ST_DRAIN;
          bf_nx    = '0;
          dcnt_nx  = '0;
        end else begin
          bf_nx = bf + 7'd1;
        end
      end
      ST_DRAIN: begin
        // Hold off the next layer until its inputs have all been written back.
        if (dcnt == CNT_W'(D - 1)) begin
          if (layer == 3'(NTT_LAYERS - 1)) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_ISSUE;
            layer_nx = layer + 3'd1;
          end
        end else begin
          dcnt_nx = dcnt + CNT_W'(1);
        end
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Issue values are computed from next-state counters so the registered read
  // strobe lines up with the cycle the sequencer occupies ISSUE.
  assign issue_vld_nx = (state_nx == ST_ISSUE);
  assign issue_nx     = calc_issue(layer_nx, bf_nx, mode_nx == MODE_INVNTT);

  // ---- p0: registered read issue ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0       <= 1'b0;
      rd_addr_1_p0 <= '0;
      rd_addr_2_p0 <= '0;
      zeta_p0      <= '0;
    end else begin
      vld_p0       <= issue_vld_nx;
      rd_addr_1_p0 <= issue_vld_nx ? issue_nx.addr_1 : '0;
      rd_addr_2_p0 <= issue_vld_nx ? issue_nx.addr_2 : '0;
      zeta_p0      <= issue_vld_nx ? issue_nx.zeta   : '0;
    end
  end

  // ---- p0 -> pD: write-back alignment ----
  assign wb_in = '{vld: vld_p0, addr_1: rd_addr_1_p0, addr_2: rd_addr_2_p0};

  wb_delay_line #(
    .DEPTH (D),
    .WIDTH (WB_WORD_W)
  ) u_wb_delay_line (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (wb_in),
    .dout  (wb_out)
  );

  assign bus.busy      = (state != ST_IDLE);
  assign bus.done      = (state == ST_DONE);
  assign bus.bu_mode   = (state != ST_IDLE) ? mode_q : 2'd0;
  assign bus.rd_en     = vld_p0;
  assign bus.rd_addr_1 = rd_addr_1_p0;
  assign bus.rd_addr_2 = rd_addr_2_p0;
  assign bus.zeta_idx  = zeta_p0;
  assign bus.wr_en     = wb_out.vld;
  assign bus.wr_addr_1 = wb_out.addr_1;
  assign bus.wr_addr_2 = wb_out.addr_2;

endmodule

// File: doc/ntt_addr_gen.md
NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 The block SHALL have parameter RD_LATENCY, default 1, giving coefficient-RAM read latency in cycles.
REQ-002 The block SHALL have parameter BU_LATENCY, default 3, giving butterfly_core input-to-output latency in cycles.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle request to run a full 256-point transform.
REQ-007 mode  in  2  0:NTT, 1:INVNTT (butterfly_core encoding); 2,3 invalid for this block.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse at transform completion.
REQ-010 rd_en  out  1  coefficient pair read strobe.
REQ-011 rd_addr_1, rd_addr_2  out  8 each  read addresses of the butterfly pair.
REQ-012 zeta_idx  out  7  twiddle-ROM index, aligned with rd_en.
REQ-013 bu_mode  out  2  mode to butterfly_core, held constant while busy.
REQ-014 wr_en  out  1  write-back strobe for butterfly results.
REQ-015 wr_addr_1, wr_addr_2  out  8 each  write-back addresses for out_1/out_2.

Function
REQ-016 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-017 In IDLE, start=1 with mode in {0,1} SHALL latch mode and enter ISSUE with layer=0, bf=0; start with mode 2 or 3 SHALL be ignored.
REQ-018 start while not IDLE SHALL be ignored.
REQ-019 Each layer SHALL issue 128 butterflies, one per cycle in ISSUE, rd_en=1, bf counting 0..127.
REQ-020 Layer length: NTT len=128>>layer; INVNTT len=2<<layer; layer runs 0..6.
REQ-021 For bf: group=bf/len, off=bf mod len, rd_addr_1=2*len*group+off, rd_addr_2=rd_addr_1+len.
REQ-022 zeta_idx SHALL be (1<<layer)+group for NTT and (128>>layer)-1-group for INVNTT.
REQ-023 After bf=127, the FSM SHALL enter DRAIN for D=RD_LATENCY+BU_LATENCY cycles, so no read of layer L+1 precedes the last write of layer L.
REQ-024 After DRAIN, it SHALL return to ISSUE with layer+1; after layer 6, it SHALL enter DONE.
REQ-025 wr_en, wr_addr_1, wr_addr_2 SHALL equal rd_en, rd_addr_1, rd_addr_2 delayed exactly D cycles.
REQ-026 With the start cycle as 0, layer L first issue SHALL be at cycle 1+L*(128+D).
REQ-027 done SHALL pulse in DONE, the cycle after the final wr_en, then return to IDLE; busy SHALL drop with done.
REQ-028 bu_mode SHALL output the latched mode while busy and 0 in IDLE.
REQ-029 rd_en SHALL be 0 in IDLE, DRAIN and DONE.

Reset
REQ-030 On rst=0, the block SHALL asynchronously enter IDLE and clear layer, bf, latched mode and the whole delay line.
REQ-031 During reset, all outputs SHALL be 0.
REQ-032 Reset mid-transform SHALL abort it with no further wr_en and no done.

Structure
REQ-033 A shared include kyber_defs.vh SHALL hold KYBER_N=256, KYBER_Q=3329, NTT_LAYERS=7, the mode encodings and the FSM state encodings.
REQ-034 The D-deep valid+address shift register SHALL be sub-module wb_delay_line, parameterised by depth and width.
REQ-035 Address and zeta arithmetic SHALL be combinational from layer/bf and registered once with rd_en.

Verification
REQ-036 NTT, D=4: start at cycle 0 -> rd_en at cycle 1 with addr (0,128), zeta 1; cycle 2 with (1,129), zeta 1.
REQ-037 NTT layer 6: first issue at cycle 793 with (0,2), zeta 64; bf=127 gives (253,255), zeta 127; done at cycle 925.
REQ-038 INVNTT layer 0: bf=0 gives (0,2), zeta 127; bf=127 gives (253,255), zeta 64; layer 6 bf=0 gives (0,128), zeta 1.
REQ-039 Layer boundary: no rd_en during the 4 DRAIN cycles; the last layer-0 wr_en precedes the first layer-1 rd_en.
REQ-040 start with mode=2, and start while busy -> ignored; busy unaffected, transform count unchanged.
REQ-041 rst=0 at cycle 300 -> all outputs 0 asynchronously; no wr_en or done afterward; a new start runs a full, correct transform.
